// File: rtl/alub_src_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alub_src_sequencer
// Brief    : ALU B-operand source/immediate sequencer; IMM16 is split into
//            a low-byte issue and a supervised high-byte issue.
// Revision : 1.0
// ============================================================================
module alub_src_sequencer #(
  parameter int TIMEOUT = 15,
  parameter int CW      = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic [2:0] OPCLASS,
  input  logic [3:0] ARGA,
  input  logic [3:0] ARGB,
  input  logic [1:0] LDSINCF,
  input  logic       FLUSH,
  input  logic       ALU_READY,
  output logic [2:0] ALUB_SRCX,
  output logic [3:0] ARGA_X,
  output logic [3:0] ARGB_X,
  output logic [1:0] LDSINCF_X,
  output logic       OUT_VALID,
  output logic       OUT_LAST,
  output logic       HI_PEND,
  output logic       ERR
);

  localparam logic [2:0] OPC_REG_B = 3'd0;
  localparam logic [2:0] OPC_U4    = 3'd1;
  localparam logic [2:0] OPC_U4_0  = 3'd2;
  localparam logic [2:0] OPC_U6    = 3'd3;
  localparam logic [2:0] OPC_U6_0  = 3'd4;
  localparam logic [2:0] OPC_U8    = 3'd5;
  localparam logic [2:0] OPC_IMM16 = 3'd6;

  localparam logic [2:0] SRC_REG_B = 3'd0;
  localparam logic [2:0] SRC_U8H   = 3'd1;
  localparam logic [2:0] SRC_U8    = 3'd2;
  localparam logic [2:0] SRC_U4    = 3'd3;
  localparam logic [2:0] SRC_U4_0  = 3'd4;
  localparam logic [2:0] SRC_U6    = 3'd5;
  localparam logic [2:0] SRC_U6_0  = 3'd6;

  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    PH_IDLE = 1'b0,
    PH_HIGH = 1'b1
  } phase_t;

  phase_t          phase, phase_nx;
  logic [CW-1:0]   tmo_cnt, tmo_nx;
  logic [2:0]      srcx_nx;
  logic [3:0]      arga_nx, argb_nx;
  logic [1:0]      lds_nx;
  logic            valid_nx, last_nx, err_nx;
  logic            ready_c, accept, tmo_hit;

  // Single output register with no skid: a new beat only fits when the
  // current issue is absent or being consumed this very cycle.
  assign ready_c  = RESET && (!OUT_VALID || ALU_READY);
  assign accept   = IN_VALID && ready_c && !FLUSH;
  assign tmo_hit  = (phase == PH_HIGH) && !accept && (tmo_cnt == TMO_LAST);
  assign IN_READY = ready_c;
  assign HI_PEND  = (phase == PH_HIGH);

  always_comb begin
    phase_nx = phase;
    tmo_nx   = tmo_cnt;
    srcx_nx  = ALUB_SRCX;
    arga_nx  = ARGA_X;
    argb_nx  = ARGB_X;
    lds_nx   = LDSINCF_X;
    valid_nx = ALU_READY ? 1'b0 : OUT_VALID;
    last_nx  = OUT_LAST;
    err_nx   = 1'b0;

    if (FLUSH) begin
      valid_nx = 1'b0;
      last_nx  = 1'b0;
      phase_nx = PH_IDLE;
      tmo_nx   = '0;
    end else if (accept) begin
      valid_nx = 1'b1;
      arga_nx  = ARGA;
      argb_nx  = ARGB;
      lds_nx   = LDSINCF;
      if (phase == PH_HIGH) begin
        // The beat after an IMM16 is always the high byte, class ignored.
        srcx_nx  = SRC_U8H;
        last_nx  = 1'b1;
        phase_nx = PH_IDLE;
        tmo_nx   = '0;
      end else begin
        last_nx = 1'b1;
        case (OPCLASS)
          OPC_REG_B: srcx_nx = SRC_REG_B;
          OPC_U4:    srcx_nx = SRC_U4;
          OPC_U4_0:  srcx_nx = SRC_U4_0;
          OPC_U6:    srcx_nx = SRC_U6;
          OPC_U6_0:  srcx_nx = SRC_U6_0;
          OPC_U8:    srcx_nx = SRC_U8;
          OPC_IMM16: begin
            srcx_nx  = SRC_U8;
            last_nx  = 1'b0;
            phase_nx = PH_HIGH;
            tmo_nx   = '0;
          end
          default: begin
            srcx_nx = SRC_REG_B;
            err_nx  = 1'b1;
          end
        endcase
      end
    end else if (phase == PH_HIGH) begin
      if (tmo_hit) begin
        phase_nx = PH_IDLE;
        tmo_nx   = '0;
        err_nx   = 1'b1;
      end else begin
        tmo_nx = tmo_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      phase     <= PH_IDLE;
      tmo_cnt   <= '0;
      ALUB_SRCX <= '0;
      ARGA_X    <= '0;
      ARGB_X    <= '0;
      LDSINCF_X <= '0;
      OUT_VALID <= 1'b0;
      OUT_LAST  <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      phase     <= phase_nx;
      tmo_cnt   <= tmo_nx;
      ALUB_SRCX <= srcx_nx;
      ARGA_X    <= arga_nx;
      ARGB_X    <= argb_nx;
      LDSINCF_X <= lds_nx;
      OUT_VALID <= valid_nx;
      OUT_LAST  <= last_nx;
      ERR       <= err_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alub_src_sequencer.sv
`default_nettype none
// Self-checking bench for alub_src_sequencer: vector table plus scoreboard.
module tb_alub_src_sequencer;

  logic       CLK = 1'b0;
  logic       RESET, IN_VALID, FLUSH, ALU_READY;
  logic [2:0] OPCLASS;
  logic [3:0] ARGA, ARGB;
  logic [1:0] LDSINCF;
  logic       IN_READY, OUT_VALID, OUT_LAST, HI_PEND, ERR;
  logic [2:0] ALUB_SRCX;
  logic [3:0] ARGA_X, ARGB_X;
  logic [1:0] LDSINCF_X;

  alub_src_sequencer #(.TIMEOUT(15), .CW(8)) dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OPCLASS(OPCLASS), .ARGA(ARGA), .ARGB(ARGB), .LDSINCF(LDSINCF),
    .FLUSH(FLUSH), .ALU_READY(ALU_READY), .ALUB_SRCX(ALUB_SRCX),
    .ARGA_X(ARGA_X), .ARGB_X(ARGB_X), .LDSINCF_X(LDSINCF_X),
    .OUT_VALID(OUT_VALID), .OUT_LAST(OUT_LAST), .HI_PEND(HI_PEND), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0] srcx;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] l;
    logic       last;
    logic       chk_l;
  } exp_t;

  typedef struct {
    logic [2:0] opc;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] l;
    logic [2:0] xs;
    logic       xl;
    logic       xe;
    logic       xh;
    logic       xcl;
  } vec_t;

  exp_t q[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic m_ov  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // One clock: apply inputs, check IN_READY, clock, then check results.
  task automatic cycle(input logic v, input logic [2:0] opc, input logic [3:0] a,
                       input logic [3:0] b, input logic [1:0] l, input logic fl,
                       input logic ar, input logic [2:0] xs, input logic xl,
                       input logic xe, input logic xh, input logic xcl);
    logic xr, acc;
    exp_t e;
    IN_VALID = v; OPCLASS = opc; ARGA = a; ARGB = b; LDSINCF = l;
    FLUSH = fl; ALU_READY = ar;
    #1;
    xr  = !m_ov || ar;
    acc = v && xr && !fl;
    chk("in_ready", int'(IN_READY), int'(xr));
    if (acc) begin
      e.srcx = xs; e.a = a; e.b = b; e.l = l; e.last = xl; e.chk_l = xcl;
      q.push_back(e);
    end
    @(posedge CLK);
    #1;
    m_ov = fl ? 1'b0 : (acc ? 1'b1 : (ar ? 1'b0 : m_ov));
    chk("out_valid", int'(OUT_VALID), int'(m_ov));
    chk("err", int'(ERR), int'(xe));
    chk("hi_pend", int'(HI_PEND), int'(xh));
    if (fl) chk("out_last_flush", int'(OUT_LAST), 0);
    if (acc) begin
      if (q.size() == 0) chk("sb_underflow", 1, 0);
      else cur = q.pop_front();
    end
    if (m_ov) begin
      chk("srcx", int'(ALUB_SRCX), int'(cur.srcx));
      chk("arga_x", int'(ARGA_X), int'(cur.a));
      chk("argb_x", int'(ARGB_X), int'(cur.b));
      chk("out_last", int'(OUT_LAST), int'(cur.last));
      if (cur.chk_l) chk("ldsincf_x", int'(LDSINCF_X), int'(cur.l));
    end
  endtask

  task automatic idle(input logic ar, input logic xh);
    cycle(1'b0, 3'd0, 4'h0, 4'h0, 2'd0, 1'b0, ar, 3'd0, 1'b0, 1'b0, xh, 1'b0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_srcx"}, int'(ALUB_SRCX), 0);
    chk({tag, "_arga"}, int'(ARGA_X), 0);
    chk({tag, "_argb"}, int'(ARGB_X), 0);
    chk({tag, "_lds"}, int'(LDSINCF_X), 0);
    chk({tag, "_valid"}, int'(OUT_VALID), 0);
    chk({tag, "_last"}, int'(OUT_LAST), 0);
    chk({tag, "_hipend"}, int'(HI_PEND), 0);
    chk({tag, "_err"}, int'(ERR), 0);
  endtask

  vec_t tbl[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{3'd0, 4'h1, 4'h2, 2'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{3'd1, 4'h4, 4'h5, 2'd1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{3'd2, 4'h6, 4'h7, 2'd0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{3'd3, 4'h0, 4'hA, 2'd2, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{3'd4, 4'h8, 4'h9, 2'd3, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{3'd5, 4'hB, 4'hC, 2'd1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{3'd7, 4'hD, 4'hE, 2'd2, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{3'd6, 4'h3, 4'h4, 2'd1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{3'd6, 4'h1, 4'h2, 2'd0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{3'd6, 4'h5, 4'h6, 2'd2, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{3'd7, 4'h7, 4'h8, 2'd0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{3'd0, 4'hF, 4'hF, 2'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1};

    // Power-on reset with busy inputs
    RESET = 1'b0; IN_VALID = 1'b1; OPCLASS = 3'd3; ARGA = 4'h5; ARGB = 4'h5;
    LDSINCF = 2'd1; FLUSH = 1'b0; ALU_READY = 1'b1;
    cur = '{3'd0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0};
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_in_ready", int'(IN_READY), 0);
    chk_reset_values("rst");
    RESET = 1'b1;

    // Basic U6 issue, then the full vector table back-to-back
    cycle(1'b1, 3'd3, 4'h0, 4'hA, 2'd2, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++)
      cycle(1'b1, tbl[i].opc, tbl[i].a, tbl[i].b, tbl[i].l, 1'b0, 1'b1,
            tbl[i].xs, tbl[i].xl, tbl[i].xe, tbl[i].xh, tbl[i].xcl);
    idle(1'b1, 1'b0);

    // Output stall: U4 held for 3 cycles, queued U6 waits for ALU_READY
    cycle(1'b1, 3'd1, 4'h2, 4'h9, 2'd1, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 3'd3, 4'hC, 4'hD, 2'd2, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 3'd3, 4'hC, 4'hD, 2'd2, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1'b1, 1'b0);

    // IMM16 low with no high beat: ERR on the 15th cycle after the low issue
    cycle(1'b1, 3'd6, 4'h3, 4'h4, 2'd0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 1; k <= 15; k++) begin
      IN_VALID = 1'b0; OPCLASS = 3'd0; FLUSH = 1'b0; ALU_READY = 1'b1;
      cycle(1'b0, 3'd0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b1, 3'd0, 1'b0,
            (k == 15), (k < 15), 1'b0);
    end
    idle(1'b1, 1'b0);
    cycle(1'b1, 3'd5, 4'h6, 4'h7, 2'd3, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1);

    // High beat arriving on the timeout cycle wins without ERR
    cycle(1'b1, 3'd6, 4'h9, 4'h8, 2'd0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 1; k <= 14; k++) idle(1'b1, 1'b1);
    cycle(1'b1, 3'd0, 4'hA, 4'hB, 2'd0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 1'b0);

    // FLUSH during HI_PEND drops the beat, then a reserved class errs
    cycle(1'b1, 3'd6, 4'h1, 4'h1, 2'd0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 3'd6, 4'h5, 4'h5, 2'd0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 3'd7, 4'h2, 4'h3, 2'd1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(1'b1, 1'b0);

    // Reset mid-IMM16 with FLUSH also high
    cycle(1'b1, 3'd6, 4'hE, 4'hD, 2'd3, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    RESET = 1'b0; FLUSH = 1'b1; IN_VALID = 1'b1; OPCLASS = 3'd6;
    #1;
    chk("rst2_in_ready", int'(IN_READY), 0);
    @(posedge CLK);
    #1;
    chk_reset_values("rst2");
    RESET = 1'b1; m_ov = 1'b0;
    cycle(1'b1, 3'd5, 4'h4, 4'h2, 2'd2, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1'b1, 1'b0);

    chk("sb_leftover", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alub_src_sequencer.md
Name: alub_src_sequencer

Overview:
Sequences the ALU B-operand source select and immediate-field registers for the ALU B input mux, one decoded operand beat at a time.
Accepts beats from decode over a valid/ready handshake and presents registered ALUB_SRCX/ARGA_X/ARGB_X/LDSINCF_X to the mux and ALU with a valid/ready output stage.
Splits a 16-bit immediate into two issues: U8 (low byte), then U8H (high byte over the ALU feedback).
Supervises the high-byte wait with a timeout counter.

Parameters:
TIMEOUT, 15, cycles the IMM16 high-byte beat may be awaited before error abort (1..255)
CW, 8, width of TMO_CNT

Ports:
CLK  in  1  system clock, all state on rising edge
RESET  in  1  synchronous reset, active-low
IN_VALID  in  1  decode beat valid
IN_READY  out  1  sequencer can accept beat
OPCLASS  in  3  0 REG_B,1 U4,2 U4_0,3 U6,4 U6_0,5 U8,6 IMM16,7 reserved
ARGA  in  4  instruction A field
ARGB  in  4  instruction B field
LDSINCF  in  2  load/store increment field
FLUSH  in  1  synchronous pipeline flush
ALU_READY  in  1  ALU consumes current output this cycle
ALUB_SRCX  out  3  mux select: 0 REG_B,1 U8H,2 U8,3 U4,4 U4_0,5 U6,6 U6_0
ARGA_X  out  4  registered A field
ARGB_X  out  4  registered B field
LDSINCF_X  out  2  registered increment field
OUT_VALID  out  1  outputs hold an unconsumed issue
OUT_LAST  out  1  final issue of the operand (0 only on IMM16 low issue)
HI_PEND  out  1  IMM16 low byte issued, high beat awaited
ERR  out  1  one-cycle pulse: reserved OPCLASS or timeout

Behaviour:
- Reset (RESET=0 at edge): ALUB_SRCX=0, ARGA_X=ARGB_X=0, LDSINCF_X=0, OUT_VALID=0, OUT_LAST=0, HI_PEND=0, ERR=0, TMO_CNT=0. Reset dominates FLUSH and all other inputs.
- IN_READY = !OUT_VALID || ALU_READY. This is combinational, with a single output register and no skid. IN_READY=0 while RESET=0.
- Accept = IN_VALID && IN_READY && !FLUSH. Outputs load on the edge after accept. Latency is 1 cycle. Outputs are held stable while OUT_VALID && !ALU_READY.
- OUT_VALID next = accept ? 1 : (ALU_READY ? 0 : OUT_VALID).
- Idle-phase mapping (HI_PEND=0):
  - REG_B→0
  - U4→3
  - U4_0→4
  - U6→5
  - U6_0→6
  - U8→2
  - All of the above set OUT_LAST=1.
  - IMM16→2 with OUT_LAST=0, sets HI_PEND=1, clears TMO_CNT.
  - Reserved 7→0 with OUT_LAST=1, ERR pulse.
  - ARGA/ARGB/LDSINCF are latched for every class.
- High phase (HI_PEND=1): the next accepted beat is the high byte, regardless of OPCLASS. It issues ALUB_SRCX=1 with ARGA_X/ARGB_X from the beat and OUT_LAST=1, and clears HI_PEND. No ERR is raised in this phase for OPCLASS=7.
- Timeout: while HI_PEND=1 and no accept, TMO_CNT increments each cycle. On the cycle TMO_CNT==TIMEOUT-1 with no accept:
  - HI_PEND←0, TMO_CNT←0, ERR pulses.
  - OUT_VALID is unaffected.
  - An accept on that same cycle wins: it is a normal high issue with no ERR.
- FLUSH (RESET=1): next edge OUT_VALID=0, OUT_LAST=0, HI_PEND=0, TMO_CNT=0, ERR=0. Beats presented that cycle are dropped. ALUB_SRCX/ARG*_X keep their values (don't-care while invalid).
- Back-to-back: with ALU_READY=1 every cycle, one issue per cycle. An IMM16 pair completes in 2 consecutive cycles.
- ERR is asserted for exactly one cycle per event and is never held.

Test Plan:
- Reset, then IN_VALID=1 OPCLASS=3 ARGB=0xA LDSINCF=2, ALU_READY=1 → next cycle OUT_VALID=1 ALUB_SRCX=5 ARGB_X=0xA LDSINCF_X=2 OUT_LAST=1.
- IMM16 beat ARGA=0x3 ARGB=0x4, then beat ARGA=0x1 ARGB=0x2 → cycle1 SRCX=2 {A,B}=0x34 LAST=0 HI_PEND=1. Cycle2 SRCX=1 {A,B}=0x12 LAST=1 HI_PEND=0.
- Output stall: issue U4 with ALU_READY=0 for 3 cycles → IN_READY=0, outputs frozen. ALU_READY=1 → IN_READY=1, queued beat issues next cycle.
- IMM16 low issued, no further beats, TIMEOUT=15 → ERR single pulse 15 cycles after the low issue, HI_PEND→0. A subsequent U8 maps to SRCX=2.
- FLUSH during HI_PEND with IN_VALID=1 → beat dropped, OUT_VALID=0, HI_PEND=0. Next OPCLASS=7 → SRCX=0 plus ERR pulse.
- RESET=0 asserted mid-IMM16 with FLUSH=1 → all outputs return to reset values the next edge.
